// File: rtl/vmem_arbiter.sv
// Frame-buffer port arbiter: display reads always win, then the clear engine,
// then buffered producer writes drained from a small FIFO.
module vmem_arbiter #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_disp_req,
    input  logic [9:0]                  i_disp_h,
    input  logic [8:0]                  i_disp_v,
    output logic                        o_disp_valid,
    output logic [23:0]                 o_disp_data,
    input  logic                        i_wr_valid,
    output logic                        o_wr_ready,
    input  logic [9:0]                  i_wr_h,
    input  logic [8:0]                  i_wr_v,
    input  logic [23:0]                 i_wr_data,
    input  logic                        i_clr_start,
    input  logic [23:0]                 i_clr_color,
    output logic                        o_clr_busy,
    output logic                        o_clr_done,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic [7:0]                  o_drop_cnt,
    output logic                        o_mem_en,
    output logic                        o_mem_we,
    output logic [18:0]                 o_mem_addr,
    output logic [23:0]                 o_mem_wdata,
    input  logic [23:0]                 i_mem_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [9:0]    H_LAST     = 10'(H_RES - 1);
    localparam logic [8:0]    V_LAST     = 9'(V_RES - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    typedef struct packed {
        logic [18:0] addr;
        logic [23:0] data;
    } wr_entry_t;

    state_t        r_state, w_state_next;
    wr_entry_t     r_fifo [FIFO_DEPTH];
    wr_entry_t     w_head;
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_drop;
    logic [9:0]    r_clr_h;
    logic [8:0]    r_clr_v;
    logic [23:0]   r_clr_color;
    logic          r_disp_valid, r_disp_hit;

    logic w_disp_hit, w_full, w_empty, w_wr_accept, w_wr_in_range;
    logic w_push, w_pop, w_clr_slot, w_clr_last;

    assign w_disp_hit    = i_disp_req && (i_disp_h <= H_LAST) && (i_disp_v <= V_LAST);
    assign w_full        = (r_level == FULL_LEVEL);
    assign w_empty       = (r_level == '0);
    assign w_wr_accept   = i_wr_valid && !w_full;
    assign w_wr_in_range = (i_wr_h <= H_LAST) && (i_wr_v <= V_LAST);
    assign w_push        = w_wr_accept && w_wr_in_range;
    assign w_clr_slot    = (r_state == S_CLEAR) && !w_disp_hit;
    assign w_clr_last    = (r_clr_h == H_LAST) && (r_clr_v == V_LAST);
    assign w_pop         = (r_state == S_IDLE) && !w_disp_hit && !w_empty;
    assign w_head        = r_fifo[r_rd_ptr];

    assign o_wr_ready    = !w_full;
    assign o_fifo_level  = r_level;
    assign o_drop_cnt    = r_drop;
    assign o_disp_valid  = r_disp_valid;
    // Read data is only meaningful when last cycle's request actually hit memory.
    assign o_disp_data   = r_disp_hit ? i_mem_rdata : 24'h0;

    always_comb begin
        w_state_next = r_state;
        o_clr_busy   = 1'b0;
        o_clr_done   = 1'b0;
        o_mem_en     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = 19'h0;
        o_mem_wdata  = 24'h0;
        case (r_state)
            S_IDLE:  if (i_clr_start) w_state_next = S_CLEAR;
            S_CLEAR: begin
                o_clr_busy = 1'b1;
                if (w_clr_slot && w_clr_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                o_clr_done   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (!i_reset) begin
            if (w_disp_hit) begin
                o_mem_en   = 1'b1;
                o_mem_addr = {i_disp_h, i_disp_v};
            end else if (w_clr_slot) begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {r_clr_h, r_clr_v};
                o_mem_wdata = r_clr_color;
            end else if (w_pop) begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = w_head.addr;
                o_mem_wdata = w_head.data;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_level      <= '0;
            r_drop       <= 8'h0;
            r_clr_h      <= 10'h0;
            r_clr_v      <= 9'h0;
            r_clr_color  <= 24'h0;
            r_disp_valid <= 1'b0;
            r_disp_hit   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_disp_valid <= i_disp_req;
            r_disp_hit   <= w_disp_hit;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LW'(1);
            else if (!w_push && w_pop) r_level <= r_level - LW'(1);
            if (w_wr_accept && !w_wr_in_range && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
            // Column-major fill: v runs fastest, h advances on v wrap.
            if ((r_state == S_IDLE) && i_clr_start) begin
                r_clr_color <= i_clr_color;
                r_clr_h     <= 10'h0;
                r_clr_v     <= 9'h0;
            end else if (w_clr_slot) begin
                if (r_clr_v == V_LAST) begin
                    r_clr_v <= 9'h0;
                    r_clr_h <= r_clr_h + 10'd1;
                end else begin
                    r_clr_v <= r_clr_v + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= '{addr: {i_wr_h, i_wr_v}, data: i_wr_data};
    end
endmodule

// File: doc/vmem_arbiter.md
# vmem_arbiter

Arbiter and sequencer for the single-port 24-bit pixel frame buffer behind the VGA scanout path. It gives the display read stream absolute priority every cycle. Pixel writes from a producer (keyboard/console logic or a CPU bridge) are buffered in a small FIFO and drained into free memory slots. A built-in clear engine fills the whole frame with one colour. It sits between `vga_ctrl` (reads) and the frame-buffer RAM, replacing direct combinational access to pixel memory.

## Interface
- `H_RES`, 640, visible horizontal pixels; valid h range 0..H_RES-1
- `V_RES`, 480, visible vertical pixels; valid v range 0..V_RES-1
- `FIFO_DEPTH`, 4, write FIFO entries (power of two, ≥2)

- `clock`  in  1  single clock for all logic
- `reset`  in  1  synchronous, active-high
- `disp_req`  in  1  display read request this cycle
- `disp_h`  in  10  display x coordinate
- `disp_v`  in  9  display y coordinate
- `disp_valid`  out  1  disp_data valid (response to previous cycle's request)
- `disp_data`  out  24  pixel RGB {R,G,B}
- `wr_valid`  in  1  producer write request
- `wr_ready`  out  1  FIFO can accept (= not full)
- `wr_h`  in  10  write x
- `wr_v`  in  9  write y
- `wr_data`  in  24  write RGB
- `clr_start`  in  1  one-cycle pulse: start full-frame clear
- `clr_color`  in  24  fill colour, sampled on accepted clr_start
- `clr_busy`  out  1  clear in progress
- `clr_done`  out  1  one-cycle pulse after last clear write
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `drop_cnt`  out  8  saturating count of discarded out-of-range writes
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  19  {h[9:0], v[8:0]}
- `mem_wdata`  out  24  write data
- `mem_rdata`  in  24  read data, synchronous, 1-cycle latency

## Operation
- Memory address is always `{h, v}` concatenated; no multiply.
- Slot priority per cycle: (1) display read, (2) clear write, (3) FIFO drain write.
- Display: if `disp_req` and coordinates are in range, drive mem_en=1, we=0, addr. Out-of-range requests do not access memory; the response is 0.
- Write accept: handshake when `wr_valid && wr_ready`.
  - In-range entries are pushed into the FIFO.
  - Out-of-range entries are accepted but not pushed; `drop_cnt` increments and saturates at 255.
- FIFO is registered, first-in first-out. Push and pop in the same cycle are legal when not full, and the level stays unchanged.
- FSM states:
  - IDLE: FIFO drains when display does not use the slot. `clr_start` → CLEAR. On entry, latch `clr_color`, set the clear counters to h=0, v=0, and assert `clr_busy`.
  - CLEAR: on each slot not taken by display, write `clr_color` at (h,v). v increments first; at v=V_RES-1, v wraps to 0 and h increments. The write at (H_RES-1, V_RES-1) → DONE.
  - DONE: one cycle. `clr_done`=1, `clr_busy`=0 → IDLE.
- During CLEAR and DONE the FIFO does not drain. It keeps accepting until full; its contents then drain after the clear, so later writes overwrite the fill colour.
- `clr_start` while in CLEAR or DONE is ignored.
- `clr_start` in IDLE takes the slot from a pending FIFO drain starting the next cycle. An in-flight write for the current cycle still completes.

## Timing
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_valid=0, disp_data=0, clr_busy=0, clr_done=0, fifo_level=0, drop_cnt=0, FSM=IDLE, FIFO empty. `wr_ready`=1 from the first cycle after reset deasserts.
- Memory control outputs are combinational from the request, state and FIFO head.
- Display latency: request in cycle n → disp_valid=1 with disp_data in cycle n+1. disp_data is 0 for out-of-range requests and held at 0 when disp_valid=0.
- Write latency: accepted in cycle n → earliest memory write in cycle n+1, if the slot is free.
- Clear duration: H_RES×V_RES free slots. With no display traffic, clr_busy is high for exactly H_RES×V_RES cycles, then clr_done pulses in the next cycle.
- `wr_ready` = !full, combinational from registered occupancy. A full FIFO popped this cycle does not reopen `wr_ready` until the next cycle.
- Reset mid-clear or with a non-empty FIFO: everything returns to reset values in the next cycle, and queued writes are lost.

## Test plan
- Reset with the FIFO half full and clear active → next cycle: fifo_level=0, clr_busy=0, mem_en=0, wr_ready=1.
- Display read at (5,7) with memory preloaded 0x123456 at addr {10'd5,9'd7} → cycle n: mem_addr=0x00A07, mem_we=0. Cycle n+1: disp_valid=1, disp_data=0x123456.
- disp_req held high while 4 writes are issued (FIFO_DEPTH=4) → fifo_level reaches 4 and wr_ready=0. A 5th write stalls. Dropping disp_req drains 4 writes in 4 consecutive cycles in order.
- Write to (640,0) and (0,480) → no mem write; drop_cnt=2. After 300 such writes, drop_cnt=255.
- With H_RES=4 and V_RES=3 for this bench, clr_start with color 0xFF0000 and no display traffic → 12 writes, address order {0,0},{0,1},{0,2},{1,0}…{3,2}. clr_done pulses on cycle 13; a FIFO write queued during the clear lands afterwards.
- disp_req alternating every cycle during CLEAR → clear writes occur only in idle cycles. clr_busy stays high for 24 cycles, and display responses are unaffected.
